// File: rtl/hicore_wb_arbiter_if.sv
// Write-back request bundle between the execution units and the ROB write-back arbiter.
// master = requesting side (units/flush source), slave = arbiter side.
interface hicore_wb_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int PTR_W  = 4,
  parameter int INFO_W = 38
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_cancel;
  logic [N_REQ*PTR_W-1:0]  req_ptr;
  logic [N_REQ*INFO_W-1:0] req_info;
  logic [N_REQ-1:0]        req_ready;
  logic                    flush;
  logic                    wb_wen;
  logic [PTR_W-1:0]        wb_ptr;
  logic [INFO_W-1:0]       wb_info;

  modport master (
    output req_valid, req_cancel, req_ptr, req_info, flush,
    input  req_ready, wb_wen, wb_ptr, wb_info
  );

  modport slave (
    input  req_valid, req_cancel, req_ptr, req_info, flush,
    output req_ready, wb_wen, wb_ptr, wb_info
  );
endinterface

// File: rtl/hicore_wb_arbiter.sv
// Round-robin arbiter sharing the single ROB write-back port among N_REQ execution units.
// One registered output stage; cancel and flush requests are acked without being written.
module hicore_wb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int PTR_W  = 4,
  parameter int INFO_W = 38
) (
  input  logic                clk,
  input  logic                rst_n,
  hicore_wb_arbiter_if.slave  bus
);
  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  gnt_oh;
  logic [N_REQ-1:0]  ack;
  logic              gnt_found;
  logic [RR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]  gnt_ptr;
  logic [INFO_W-1:0] gnt_info;

  logic [RR_W-1:0]   rr_ptr;
  logic              wen_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [INFO_W-1:0] info_q;

  assign elig = bus.req_valid & ~bus.req_cancel & {N_REQ{~bus.flush}};

  // Two passes: indices at/above rr_ptr first, then wrap to the low indices.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && elig[i] && (i >= int'(rr_ptr))) begin
        gnt_found = 1'b1;
        gnt_idx   = RR_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && elig[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = RR_W'(i);
      end
    end
  end

  always_comb begin
    gnt_oh   = '0;
    gnt_ptr  = '0;
    gnt_info = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_found && (gnt_idx == RR_W'(i))) begin
        gnt_oh[i] = 1'b1;
        gnt_ptr   = bus.req_ptr[i*PTR_W +: PTR_W];
        gnt_info  = bus.req_info[i*INFO_W +: INFO_W];
      end
    end
  end

  // Cancelled and flushed requests are consumed so the units can move on.
  assign ack = (bus.req_valid & bus.req_cancel)
             | (bus.req_valid & {N_REQ{bus.flush}})
             | gnt_oh;

  assign bus.req_ready = rst_n ? ack : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      wen_q  <= 1'b0;
      ptr_q  <= '0;
      info_q <= '0;
    end else if (gnt_found) begin
      rr_ptr <= (gnt_idx == RR_W'(N_REQ - 1)) ? '0 : gnt_idx + RR_W'(1);
      wen_q  <= 1'b1;
      ptr_q  <= gnt_ptr;
      info_q <= gnt_info;
    end else begin
      wen_q  <= 1'b0;
    end
  end

  // Flush also kills a write that was registered in the previous cycle.
  assign bus.wb_wen  = wen_q & ~bus.flush;
  assign bus.wb_ptr  = ptr_q;
  assign bus.wb_info = info_q;
endmodule

// File: tb/tb_hicore_wb_arbiter.sv
// Directed and randomized checks of the ROB write-back arbiter.
module tb_hicore_wb_arbiter;
  localparam int N  = 4;
  localparam int PW = 4;
  localparam int IW = 38;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hicore_wb_arbiter_if #(.N_REQ(N), .PTR_W(PW), .INFO_W(IW)) bus ();

  hicore_wb_arbiter #(.N_REQ(N), .PTR_W(PW), .INFO_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] r_ptr  [N];
  logic [IW-1:0] r_info [N];

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] c, input logic f);
    bus.req_valid  = v;
    bus.req_cancel = c;
    bus.flush      = f;
    for (int i = 0; i < N; i++) begin
      bus.req_ptr[i*PW +: PW]  = r_ptr[i];
      bus.req_info[i*IW +: IW] = r_info[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(4'b1111, 4'b0011, 1'b0);
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    n_checks++; if (bus.wb_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", bus.wb_wen); end
    n_checks++; if (bus.wb_ptr !== '0 || bus.wb_info !== '0) begin n_fail++; $display("FAIL reset_data ptr=%h info=%h exp=0", bus.wb_ptr, bus.wb_info); end
    rst_n = 1'b1;
    drive(4'b0110, 4'b0000, 1'b0);
    #2;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL first_grant got=%b exp=0010", bus.req_ready); end
    tick();
    n_checks++; if (bus.wb_wen !== 1'b1 || bus.wb_ptr !== r_ptr[1]) begin n_fail++; $display("FAIL first_write wen=%b ptr=%h exp 1/%h", bus.wb_wen, bus.wb_ptr, r_ptr[1]); end
    // async reset in the middle of a registered write
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.wb_wen !== 1'b0 || bus.wb_ptr !== '0 || bus.wb_info !== '0) begin n_fail++; $display("FAIL midreset_out wen=%b ptr=%h info=%h exp 0", bus.wb_wen, bus.wb_ptr, bus.wb_info); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL midreset_ready got=%b exp=0000", bus.req_ready); end
    tick();
    rst_n = 1'b1;
    #2;
    n_checks++; if (dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr got=%0d exp=0", dut.rr_ptr); end
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL post_reset_grant got=%b exp=0010", bus.req_ready); end
    tick();
    drive('0, '0, 1'b0);
    tick();
  endtask

  task automatic test_single();
    drive(4'b0100, 4'b0000, 1'b0);
    #2;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    tick();
    drive('0, '0, 1'b0);
    n_checks++; if (bus.wb_wen !== 1'b1 || bus.wb_ptr !== 4'h5 || bus.wb_info !== 38'hABC) begin n_fail++; $display("FAIL single_write wen=%b ptr=%h info=%h exp 1/5/abc", bus.wb_wen, bus.wb_ptr, bus.wb_info); end
    tick();
    n_checks++; if (bus.wb_wen !== 1'b0 || bus.wb_ptr !== 4'h5) begin n_fail++; $display("FAIL single_idle wen=%b ptr=%h exp 0/5", bus.wb_wen, bus.wb_ptr); end
  endtask

  task automatic test_all_valid();
    logic [N-1:0] v;
    do_reset();
    v = 4'b1111;
    drive(v, '0, 1'b0);
    for (int k = 0; k < N; k++) begin
      #2;
      n_checks++; if (bus.req_ready !== 4'(1 << k)) begin n_fail++; $display("FAIL all_ready%0d got=%b exp=%b", k, bus.req_ready, 4'(1 << k)); end
      tick();
      n_checks++; if (bus.wb_wen !== 1'b1 || bus.wb_ptr !== r_ptr[k] || bus.wb_info !== r_info[k]) begin n_fail++; $display("FAIL all_write%0d wen=%b ptr=%h info=%h exp 1/%h/%h", k, bus.wb_wen, bus.wb_ptr, bus.wb_info, r_ptr[k], r_info[k]); end
      v[k] = 1'b0;
      drive(v, '0, 1'b0);
    end
    drive(4'b1001, '0, 1'b0);
    #2;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready got=%b exp=0001", bus.req_ready); end
    tick();
    drive(4'b1000, '0, 1'b0);
    #2;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready3 got=%b exp=1000", bus.req_ready); end
    n_checks++; if (bus.wb_wen !== 1'b1 || bus.wb_ptr !== r_ptr[0]) begin n_fail++; $display("FAIL wrap_write0 wen=%b ptr=%h exp 1/%h", bus.wb_wen, bus.wb_ptr, r_ptr[0]); end
    tick();
    drive('0, '0, 1'b0);
    n_checks++; if (bus.wb_wen !== 1'b1 || bus.wb_ptr !== r_ptr[3]) begin n_fail++; $display("FAIL wrap_write3 wen=%b ptr=%h exp 1/%h", bus.wb_wen, bus.wb_ptr, r_ptr[3]); end
    tick();
    n_checks++; if (bus.wb_wen !== 1'b0) begin n_fail++; $display("FAIL all_idle wen=%b exp=0", bus.wb_wen); end
  endtask

  task automatic test_cancel();
    drive(4'b0001, '0, 1'b0);
    tick();
    drive(4'b0110, 4'b0010, 1'b0);
    #2;
    n_checks++; if (bus.req_ready !== 4'b0110) begin n_fail++; $display("FAIL cancel_ready got=%b exp=0110", bus.req_ready); end
    tick();
    drive('0, '0, 1'b0);
    n_checks++; if (bus.wb_wen !== 1'b1 || bus.wb_ptr !== r_ptr[2] || bus.wb_info !== r_info[2]) begin n_fail++; $display("FAIL cancel_write wen=%b ptr=%h exp 1/%h", bus.wb_wen, bus.wb_ptr, r_ptr[2]); end
    n_checks++; if (dut.rr_ptr !== 2'd3) begin n_fail++; $display("FAIL cancel_rr got=%0d exp=3", dut.rr_ptr); end
    drive(4'b0010, 4'b0010, 1'b0);
    #2;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL cancel_only_ready got=%b exp=0010", bus.req_ready); end
    tick();
    drive('0, '0, 1'b0);
    n_checks++; if (bus.wb_wen !== 1'b0 || dut.rr_ptr !== 2'd3) begin n_fail++; $display("FAIL cancel_only wen=%b rr=%0d exp 0/3", bus.wb_wen, dut.rr_ptr); end
  endtask

  task automatic test_flush();
    drive(4'b1000, '0, 1'b0);
    #2;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL flush_pre_ready got=%b exp=1000", bus.req_ready); end
    tick();
    drive(4'b0111, '0, 1'b1);
    #1;
    n_checks++; if (bus.wb_wen !== 1'b0) begin n_fail++; $display("FAIL flush_kill wen=%b exp=0", bus.wb_wen); end
    n_checks++; if (bus.req_ready !== 4'b0111) begin n_fail++; $display("FAIL flush_ready got=%b exp=0111", bus.req_ready); end
    n_checks++; if (bus.wb_ptr !== r_ptr[3]) begin n_fail++; $display("FAIL flush_ptr got=%h exp=%h", bus.wb_ptr, r_ptr[3]); end
    tick();
    drive('0, '0, 1'b0);
    n_checks++; if (bus.wb_wen !== 1'b0 || dut.rr_ptr !== 2'd0) begin n_fail++; $display("FAIL flush_after wen=%b rr=%0d exp 0/0", bus.wb_wen, dut.rr_ptr); end
  endtask

  task automatic test_random();
    logic [N-1:0]  pend, canc, elig, oh, exp_rdy;
    logic          fl, exp_wen, starve;
    logic [PW-1:0] exp_ptr;
    logic [IW-1:0] exp_info;
    int            mrr, g, idx, n_exp_wr, n_seen_wr;
    int            age [N];
    pend = '0; exp_wen = 1'b0; exp_ptr = '0; exp_info = '0;
    mrr = 0; n_exp_wr = 0; n_seen_wr = 0;
    for (int i = 0; i < N; i++) age[i] = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      fl = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]   = 1'b1;
          r_ptr[i]  = PW'($urandom);
          r_info[i] = {6'($urandom), 32'($urandom)};
        end
        canc[i] = pend[i] && ($urandom_range(0, 7) == 0);
      end
      drive(pend, canc, fl);
      #2;
      if (exp_wen && !fl) n_exp_wr++;
      if (bus.wb_wen === 1'b1) n_seen_wr++;
      n_checks++; if (bus.wb_wen !== (exp_wen & ~fl)) begin n_fail++; $display("FAIL rnd_wen cyc=%0d got=%b exp=%b", cyc, bus.wb_wen, exp_wen & ~fl); end
      n_checks++; if (bus.wb_ptr !== exp_ptr || bus.wb_info !== exp_info) begin n_fail++; $display("FAIL rnd_data cyc=%0d ptr=%h info=%h exp %h/%h", cyc, bus.wb_ptr, bus.wb_info, exp_ptr, exp_info); end
      elig = pend & ~canc & {N{~fl}};
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mrr + k) % N;
        if (g < 0 && elig[idx]) g = idx;
      end
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      exp_rdy = (pend & canc) | (fl ? pend : '0) | oh;
      n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); end
      starve = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (elig[i] && !bus.req_ready[i]) age[i]++;
        else age[i] = 0;
        if (age[i] >= N) starve = 1'b1;
      end
      n_checks++; if (starve) begin n_fail++; $display("FAIL rnd_starve cyc=%0d ages=%0d/%0d/%0d/%0d limit=%0d", cyc, age[0], age[1], age[2], age[3], N - 1); end
      if (g >= 0) begin
        exp_wen  = 1'b1;
        exp_ptr  = r_ptr[g];
        exp_info = r_info[g];
        mrr      = (g + 1) % N;
      end else begin
        exp_wen  = 1'b0;
      end
      pend = pend & ~exp_rdy;
      tick();
    end
    drive('0, '0, 1'b0);
    #2;
    if (exp_wen) n_exp_wr++;
    if (bus.wb_wen === 1'b1) n_seen_wr++;
    n_checks++; if (n_seen_wr !== n_exp_wr) begin n_fail++; $display("FAIL rnd_write_count got=%0d exp=%0d", n_seen_wr, n_exp_wr); end
    tick();
  endtask

  initial begin
    r_ptr[0] = 4'h9; r_info[0] = 38'h11_1111_1111;
    r_ptr[1] = 4'h3; r_info[1] = 38'h22_2222_2222;
    r_ptr[2] = 4'h5; r_info[2] = 38'h00_0000_0ABC;
    r_ptr[3] = 4'hC; r_info[3] = 38'h3F_0F0F_0F0F;
    drive('0, '0, 1'b0);
    test_reset();
    test_single();
    test_all_valid();
    test_cancel();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
